// File: rtl/memory_access_unit.sv
// ---------------------------------------------------------------------------
// memory_access_unit
//
// Purpose:
//   Memory-stage bus master for a pipelined core. It turns a load or store
//   sitting in the execute-to-memory register into a single request on a
//   simple req/ack memory bus. It stalls the upstream pipeline while the
//   access is in flight and extends the returned load lane. If no ack arrives
//   within TIMEOUT cycles, it aborts the access.
//
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   MemWriteM           - store request
//   ResultSrcM          - 2'b01 marks a load
//   AddressingControlM  - width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALUResultM          - byte address
//   WriteDataM          - right-justified store data
//   StallExt            - another hazard is holding the pipeline
//   mem_req/mem_we      - registered bus request and direction
//   mem_addr/mem_be     - registered word address and byte enables
//   mem_wdata           - registered lane-replicated store data
//   mem_ack/mem_rdata   - one-cycle completion strobe and read word
//   StallM              - combinational stall to upstream pipeline registers
//   ReadDataM           - extended load result
//   MisalignM           - combinational misaligned-access flag
//   BusErrM             - one-cycle pulse when an access times out
// ---------------------------------------------------------------------------
module memory_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  AddressingControlM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        StallExt,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        MisalignM,
  output logic        BusErrM
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_count;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_readData;
  logic        r_busErr;
  logic [2:0]  r_ctrl;
  logic [1:0]  r_offset;

  logic        w_access;
  logic        w_misalign;
  logic [1:0]  w_offset;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_loadValue;

  // A store wins over a load when both are flagged, so direction is simply
  // MemWriteM; any other instruction is not a memory access at all.
  assign w_access = MemWriteM | (ResultSrcM == 2'b01);
  assign w_offset = ALUResultM[1:0];

  // Decode the width into byte enables, replicated store data and the
  // misalignment check. Loads reuse the same enable pattern so the memory
  // side can ignore width entirely.
  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = WriteDataM;
    case (AddressingControlM[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_offset;
        w_wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        w_misalign = w_offset[0];
        w_be       = w_offset[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{WriteDataM[15:0]}};
      end
      default: begin
        w_misalign = (w_offset != 2'b00);
      end
    endcase
  end

  // Pick the addressed lane out of the returned word and extend it. The
  // width, sign and offset come from copies taken at request time, so the
  // result does not depend on what the pipeline presents during BUSY.
  always_comb begin
    w_lane      = mem_rdata >> {r_offset, 3'b000};
    w_loadValue = w_lane;
    case (r_ctrl)
      3'b000:  w_loadValue = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_loadValue = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_loadValue = {24'd0, w_lane[7:0]};
      3'b101:  w_loadValue = {16'd0, w_lane[15:0]};
      default: w_loadValue = w_lane;
    endcase
  end

  // Main controller. The request is launched on the IDLE->BUSY edge and the
  // bus outputs are frozen until the ack or the timeout retires it. An ack
  // in the same cycle as the last allowed count still completes normally.
  // DONE gives the pipeline one unstalled cycle to move the instruction on,
  // and it lingers there while something else holds the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= 8'd0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_be       <= 4'd0;
      r_wdata    <= 32'd0;
      r_readData <= 32'd0;
      r_busErr   <= 1'b0;
      r_ctrl     <= 3'd0;
      r_offset   <= 2'd0;
    end else begin
      r_busErr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_access && !w_misalign) begin
            r_state  <= BUSY;
            r_count  <= 8'd0;
            r_req    <= 1'b1;
            r_we     <= MemWriteM;
            r_addr   <= {ALUResultM[31:2], 2'b00};
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_ctrl   <= AddressingControlM;
            r_offset <= w_offset;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            r_state <= DONE;
            r_req   <= 1'b0;
            if (!r_we) r_readData <= w_loadValue;
          end else if (r_count == LastCount) begin
            r_state  <= DONE;
            r_req    <= 1'b0;
            r_busErr <= 1'b1;
            if (!r_we) r_readData <= 32'd0;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        DONE: begin
          if (!StallExt) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The stall covers the presenting cycle in IDLE and all of BUSY. A
  // misaligned access never stalls; it only raises the flag and reads as zero.
  assign StallM    = ((r_state == IDLE) && w_access && !w_misalign) || (r_state == BUSY);
  assign MisalignM = (r_state == IDLE) && w_access && w_misalign;
  assign ReadDataM = MisalignM ? 32'd0 : r_readData;

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;
  assign BusErrM   = r_busErr;

endmodule

// File: tb/tb_memory_access_unit.sv
// ---------------------------------------------------------------------------
// tb_memory_access_unit
//
// Self-checking bench for memory_access_unit. It runs a table of directed
// accesses, then a batch of random accesses whose expectations come from a
// byte-level reference model. It ends with hand-written sequences for reset
// during BUSY and for holding DONE under StallExt.
// ---------------------------------------------------------------------------
module tb_memory_access_unit;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  AddressingControlM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        StallExt;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        MisalignM;
  logic        BusErrM;

  int total = 0;
  int bad   = 0;

  memory_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .AddressingControlM(AddressingControlM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .StallExt(StallExt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .StallM(StallM), .ReadDataM(ReadDataM),
    .MisalignM(MisalignM), .BusErrM(BusErrM)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs outside the bounded loops.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, want finish before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // ackCycle is the BUSY cycle (1-based) on which the ack arrives; 0 means never.
  typedef struct {
    logic        memWrite;
    logic [1:0]  resultSrc;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackCycle;
    logic [3:0]  expBe;
    logic        expWe;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [31:0] expRead;
    int          expStall;
    int          expReq;
    int          expBusErr;
    logic        expMis;
  } vec_t;

  typedef struct {
    logic [3:0]  be;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] readData;
    int          stall;
    int          req;
    int          busErr;
    logic        mis;
    logic        changed;
    logic        timedOut;
  } obs_t;

  vec_t vecs[13];

  function automatic vec_t mkVec(
    input logic mw, input logic [1:0] rs, input logic [2:0] ctrl,
    input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
    input int ack, input logic [3:0] eBe, input logic eWe, input logic [31:0] eAddr,
    input logic [31:0] eWdata, input logic [31:0] eRead, input int eStall,
    input int eReq, input int eBusErr, input logic eMis);
    vec_t v;
    v.memWrite = mw;  v.resultSrc = rs; v.ctrl = ctrl;
    v.addr = addr;    v.wdata = wdata;  v.rdata = rdata; v.ackCycle = ack;
    v.expBe = eBe;    v.expWe = eWe;    v.expAddr = eAddr; v.expWdata = eWdata;
    v.expRead = eRead; v.expStall = eStall; v.expReq = eReq;
    v.expBusErr = eBusErr; v.expMis = eMis;
    return v;
  endfunction

  // Reference model: works from byte counts and offsets with plain arithmetic.
  // lastRead carries the load result that the unit should still be showing.
  function automatic vec_t modelAccess(
    input logic mw, input logic [1:0] rs, input logic [2:0] ctrl,
    input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
    input int ack, inout logic [31:0] lastRead);
    vec_t v;
    int bytes;
    int off;
    bit access;
    bit mis;
    bit timedOut;
    longint val;
    bytes    = (ctrl[1:0] == 2'b00) ? 1 : (ctrl[1:0] == 2'b01) ? 2 : 4;
    off      = int'(addr % 4);
    access   = mw || (rs == 2'b01);
    mis      = access && ((off % bytes) != 0);
    timedOut = (ack == 0) || (ack > TIMEOUT);
    v.memWrite = mw; v.resultSrc = rs; v.ctrl = ctrl;
    v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.ackCycle = ack;
    v.expWe    = mw;
    v.expAddr  = addr - 32'(off);
    v.expBe    = 4'(((1 << bytes) - 1) << off);
    for (int i = 0; i < 4; i++) v.expWdata[8*i +: 8] = wdata[8*(i % bytes) +: 8];
    if (!access || mis) begin
      v.expReq   = 0;
      v.expStall = 0;
    end else begin
      v.expReq   = timedOut ? TIMEOUT : ack;
      v.expStall = v.expReq + 1;
    end
    v.expBusErr = (access && !mis && timedOut) ? 1 : 0;
    if (access && !mis && !mw) begin
      if (timedOut) begin
        lastRead = 32'd0;
      end else begin
        val = longint'(rdata) / (longint'(1) << (8 * off));
        if (bytes < 4) begin
          val = val % (longint'(1) << (8 * bytes));
          if (!ctrl[2] && val >= (longint'(1) << (8 * bytes - 1)))
            val = val - (longint'(1) << (8 * bytes));
        end
        lastRead = 32'(val);
      end
    end
    v.expRead = mis ? 32'd0 : lastRead;
    v.expMis  = mis;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // Present one access, play the memory side, and record what the unit did
  // until the pipeline is released, plus one idle cycle afterwards.
  task automatic applyStimulus(input vec_t v, output obs_t o);
    bit done;
    o = '{default: 0};
    done = 1'b0;
    @(negedge clk);
    MemWriteM = v.memWrite; ResultSrcM = v.resultSrc;
    AddressingControlM = v.ctrl; ALUResultM = v.addr; WriteDataM = v.wdata;
    StallExt = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (mem_req) begin
        o.req++;
        if (o.req == 1) begin
          o.be = mem_be; o.we = mem_we; o.addr = mem_addr; o.wdata = mem_wdata;
        end else if (mem_be !== o.be || mem_we !== o.we ||
                     mem_addr !== o.addr || mem_wdata !== o.wdata) begin
          o.changed = 1'b1;
        end
      end
      mem_ack   = mem_req && (o.req == v.ackCycle);
      mem_rdata = mem_ack ? v.rdata : $urandom;
      #1;
      if (StallM)    o.stall++;
      if (MisalignM) o.mis = 1'b1;
      if (BusErrM)   o.busErr++;
      if (!StallM) begin
        done = 1'b1;
        o.readData = ReadDataM;
      end
      @(negedge clk);
    end
    o.timedOut = !done;
    MemWriteM = 1'b0; ResultSrcM = 2'b00; mem_ack = 1'b0;
    #1;
    if (mem_req) o.req++;
    if (BusErrM) o.busErr++;
  endtask

  task automatic checkVec(input string tag, input vec_t v, input obs_t o);
    checkOutput({tag, " released"}, 32'(o.timedOut), 32'd0);
    checkOutput({tag, " stall"}, 32'(o.stall), 32'(v.expStall));
    checkOutput({tag, " reqCycles"}, 32'(o.req), 32'(v.expReq));
    checkOutput({tag, " busErr"}, 32'(o.busErr), 32'(v.expBusErr));
    checkOutput({tag, " misalign"}, 32'(o.mis), 32'(v.expMis));
    checkOutput({tag, " readData"}, o.readData, v.expRead);
    if (v.expReq > 0) begin
      checkOutput({tag, " held"}, 32'(o.changed), 32'd0);
      checkOutput({tag, " be"}, 32'(o.be), 32'(v.expBe));
      checkOutput({tag, " we"}, 32'(o.we), 32'(v.expWe));
      checkOutput({tag, " addr"}, o.addr, v.expAddr);
      if (v.expWe) checkOutput({tag, " wdata"}, o.wdata, v.expWdata);
    end
  endtask

  initial begin
    obs_t o;
    vec_t v;
    logic [31:0] modelRead;
    logic [2:0] ctrlSet [5];

    ctrlSet[0] = 3'b000; ctrlSet[1] = 3'b001; ctrlSet[2] = 3'b010;
    ctrlSet[3] = 3'b100; ctrlSet[4] = 3'b101;

    //              mw    rs     ctrl    addr          wdata         rdata         ack be      we    addr          wdata         read          st rq be mis
    vecs[0]  = mkVec(1'b1, 2'b00, 3'b010, 32'h00000100, 32'hDEADBEEF, 32'h0,        2, 4'b1111, 1'b1, 32'h00000100, 32'hDEADBEEF, 32'h00000000, 3, 2, 0, 1'b0);
    vecs[1]  = mkVec(1'b0, 2'b01, 3'b000, 32'h00000203, 32'h0,        32'h80FFFFFF, 1, 4'b1000, 1'b0, 32'h00000200, 32'h0,        32'hFFFFFF80, 2, 1, 0, 1'b0);
    vecs[2]  = mkVec(1'b0, 2'b01, 3'b100, 32'h00000203, 32'h0,        32'h80FFFFFF, 1, 4'b1000, 1'b0, 32'h00000200, 32'h0,        32'h00000080, 2, 1, 0, 1'b0);
    vecs[3]  = mkVec(1'b1, 2'b00, 3'b001, 32'h00000102, 32'h0000ABCD, 32'h0,        1, 4'b1100, 1'b1, 32'h00000100, 32'hABCDABCD, 32'h00000080, 2, 1, 0, 1'b0);
    vecs[4]  = mkVec(1'b0, 2'b01, 3'b010, 32'h00000101, 32'h0,        32'h0,        1, 4'b0000, 1'b0, 32'h0,        32'h0,        32'h00000000, 0, 0, 0, 1'b1);
    vecs[5]  = mkVec(1'b0, 2'b01, 3'b010, 32'h00000300, 32'h0,        32'h0,        0, 4'b1111, 1'b0, 32'h00000300, 32'h0,        32'h00000000, 5, 4, 1, 1'b0);
    vecs[6]  = mkVec(1'b0, 2'b01, 3'b001, 32'h00000002, 32'h0,        32'h80011234, 3, 4'b1100, 1'b0, 32'h00000000, 32'h0,        32'hFFFF8001, 4, 3, 0, 1'b0);
    vecs[7]  = mkVec(1'b0, 2'b01, 3'b101, 32'h00000004, 32'h0,        32'h80011234, 1, 4'b0011, 1'b0, 32'h00000004, 32'h0,        32'h00001234, 2, 1, 0, 1'b0);
    vecs[8]  = mkVec(1'b1, 2'b00, 3'b000, 32'h00000001, 32'h123456A5, 32'h0,        1, 4'b0010, 1'b1, 32'h00000000, 32'hA5A5A5A5, 32'h00001234, 2, 1, 0, 1'b0);
    vecs[9]  = mkVec(1'b0, 2'b01, 3'b001, 32'h00000003, 32'h0,        32'h0,        1, 4'b0000, 1'b0, 32'h0,        32'h0,        32'h00000000, 0, 0, 0, 1'b1);
    vecs[10] = mkVec(1'b0, 2'b01, 3'b010, 32'h0000000C, 32'h0,        32'hCAFEF00D, 4, 4'b1111, 1'b0, 32'h0000000C, 32'h0,        32'hCAFEF00D, 5, 4, 0, 1'b0);
    vecs[11] = mkVec(1'b1, 2'b01, 3'b010, 32'h00000010, 32'h11223344, 32'h0,        1, 4'b1111, 1'b1, 32'h00000010, 32'h11223344, 32'hCAFEF00D, 2, 1, 0, 1'b0);
    vecs[12] = mkVec(1'b0, 2'b10, 3'b010, 32'h00000101, 32'h0,        32'h0,        1, 4'b0000, 1'b0, 32'h0,        32'h0,        32'hCAFEF00D, 0, 0, 0, 1'b0);

    rst = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b00; AddressingControlM = 3'b000;
    ALUResultM = 32'd0; WriteDataM = 32'd0; StallExt = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset mem_be", 32'(mem_be), 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'd0);
    checkOutput("reset mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset ReadDataM", ReadDataM, 32'd0);
    checkOutput("reset BusErrM", 32'(BusErrM), 32'd0);
    checkOutput("reset StallM", 32'(StallM), 32'd0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], o);
      checkVec($sformatf("vec%0d", i), vecs[i], o);
    end

    modelRead = vecs[12].expRead;
    for (int n = 0; n < 40; n++) begin
      v = modelAccess(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      ctrlSet[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 5)), modelRead);
      applyStimulus(v, o);
      checkVec($sformatf("rand%0d", n), v, o);
    end

    // Reset arriving in the second BUSY cycle aborts the access; a late ack
    // must not revive it or update the load result.
    @(negedge clk);
    MemWriteM = 1'b0; ResultSrcM = 2'b01; AddressingControlM = 3'b010;
    ALUResultM = 32'h00000040; mem_ack = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rstBusy req up", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ResultSrcM = 2'b00; mem_ack = 1'b1; mem_rdata = 32'h12345678;
    #1;
    checkOutput("rstBusy req dropped", 32'(mem_req), 32'd0);
    checkOutput("rstBusy idle", 32'(StallM), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checkOutput("rstBusy ReadDataM", ReadDataM, 32'd0);
    checkOutput("rstBusy req stays low", 32'(mem_req), 32'd0);
    checkOutput("rstBusy no busErr", 32'(BusErrM), 32'd0);

    // DONE must hold under StallExt; while the aligned access stays presented,
    // StallM = 0 can only mean DONE. Stray acks there are ignored.
    @(negedge clk);
    ResultSrcM = 2'b01; AddressingControlM = 3'b010; ALUResultM = 32'h00000080;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h5A5A0001;
    @(negedge clk);
    mem_ack = 1'b0; StallExt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("stallExt%0d StallM", k), 32'(StallM), 32'd0);
      checkOutput($sformatf("stallExt%0d ReadDataM", k), ReadDataM, 32'h5A5A0001);
      checkOutput($sformatf("stallExt%0d req", k), 32'(mem_req), 32'd0);
      mem_ack = 1'b1; mem_rdata = $urandom;
      @(negedge clk);
      mem_ack = 1'b0;
    end
    StallExt = 1'b0;
    #1;
    checkOutput("stallExt still DONE", 32'(StallM), 32'd0);
    @(negedge clk);
    ResultSrcM = 2'b00;
    #1;
    checkOutput("stallExt released req", 32'(mem_req), 32'd0);
    checkOutput("stallExt released ReadDataM", ReadDataM, 32'h5A5A0001);
    checkOutput("stallExt released StallM", 32'(StallM), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
